seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Refresh/segment stage for the 4-digit multiplexed 7-segment display. It generates the periodic one-cycle `rotate` strobe that advances the anode ring shifter. It also consumes the shifter's active-low anode vector, then selects and decodes the matching BCD digit. Finally it drives registered segment, decimal-point and anode pins, with anti-ghost blanking, alarm flashing and leading-zero suppression.

Parameters:
REFRESH_DIV, 100000, clk cycles between rotate pulses (per-digit dwell); must be >= 2
BLANK_CYCLES, 1000, dark cycles after each digit change; must be < REFRESH_DIV; 0 disables blanking
FLASH_TICKS, 250, rotate pulses per flash half-period; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
anode  in  4  active-low one-cold digit select from the anode shifter
digits  in  16  BCD nibbles; [3:0]=digit0 (anode[0]) … [15:12]=digit3
dp_mask  in  4  active-high decimal point per digit
blank_lz  in  1  suppress digit3 when its nibble is 0
flash  in  1  blink whole display while high
rotate  out  1  one-cycle strobe to the anode shifter
seg  out  7  active-low segments {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
an_out  out  4  active-low anode pins

Behaviour:
- One clock; all state changes on posedge clk; rst is synchronous, active-high.
- Reset values:
  - rotate=0, seg=7'h7F, dp=1, an_out=4'hF.
  - Prescaler, blank counter, flash counter and flash_phase all 0.
  - Reset asserted mid-blank or mid-flash clears everything at that edge.
- Prescaler:
  - pcnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - rotate=1 exactly in the cycles where pcnt==REFRESH_DIV-1, giving one pulse per REFRESH_DIV cycles.
  - The first pulse after reset is in cycle REFRESH_DIV-1, counting the first post-reset cycle as 0.
- Blank counter:
  - At the edge where rotate=1, bcnt loads BLANK_CYCLES.
  - Otherwise bcnt decrements while nonzero.
  - blank_win = (bcnt != 0).
- Flash:
  - fcnt counts rotate pulses 0..FLASH_TICKS-1.
  - At the rotate edge where fcnt==FLASH_TICKS-1, fcnt wraps to 0 and flash_phase toggles.
  - While flash=0, fcnt and flash_phase are held at 0, so re-enabling always starts in the visible phase.
  - flash_off = flash & flash_phase.
- Digit select from anode:
  - 1110→0, 1101→1, 1011→2, 0111→3.
  - Any other pattern is invalid and forces a dark output.
- Decode (active-low, {g..a}):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex).
  - Nibbles 10–15 → 7F (blank code).
- Output registers, 1-cycle latency: every edge, seg/dp/an_out are loaded from the current-cycle anode, digits, dp_mask, blank_lz, blank_win and flash_off.
- Dark output: an_out=F, seg=7F, dp=1. It is loaded when any of these holds:
  - rst
  - blank_win
  - flash_off
  - invalid anode
- Otherwise, for the selected digit i:
  - an_out = anode
  - seg = decode(digits[4i+3:4i])
  - dp = ~dp_mask[i]
- Leading-zero suppression: selected digit 3 with blank_lz=1 and nibble 0 gives seg=7F. an_out and dp still follow the normal rule.
- Simultaneous events (a rotate edge that also wraps the flash counter) are all applied at the same edge.
- No handshake. The shifter is required to advance on the same edge that rotate is sampled high.

Test Plan:
1. Params REFRESH_DIV=4, BLANK_CYCLES=0. Release rst, then observe 12 cycles → rotate high in cycles 3, 7, 11 only; outputs dark during reset.
2. Same params, anode=1101, digits=16'h4321, dp_mask=4'b0010 → next cycle seg=7'h24, dp=0, an_out=1101. Then digits[7:4]=4'hB → seg=7F.
3. BLANK_CYCLES=2, REFRESH_DIV=8 → bcnt=2,1 in the two cycles after each rotate edge. an_out=F is registered at those two edges, then the digit reappears.
4. FLASH_TICKS=2, REFRESH_DIV=4, flash=1 → visible for 8 cycles, then dark for 8, repeating. Dropping flash mid-dark gives visible output one cycle later.
5. anode=0111, digits[15:12]=0, blank_lz=1, dp_mask[3]=1 → seg=7F, dp=0, an_out=0111. With anode=1100 (invalid) → fully dark.
6. Assert rst for one cycle mid-blank with flash_phase=1 → all outputs dark and counters 0 on the next cycle. rotate then reappears REFRESH_DIV-1 cycles later.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Refresh and segment stage for a 4-digit multiplexed 7-segment display.
// It produces the per-digit rotate strobe for the anode ring shifter. It
// decodes the BCD digit that the shifter currently selects. It registers
// the segment, decimal-point and anode pins, applying anti-ghost blanking,
// alarm flashing and leading-zero suppression.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int FLASH_TICKS  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        flash,
  output logic        rotate,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an_out
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_LOAD = BW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FLASH_TICKS - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          blank_win;
  logic          flash_off;
  logic          sel_valid;
  logic [1:0]    sel_idx;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic          lz_kill;

  // Prescaler: rotate fires on the last count of each dwell period
  always_comb begin
    rotate = (pcnt_q == PCNT_LAST);
    pcnt_d = rotate ? '0 : pcnt_q + PW'(1);
  end

  // Blank counter: reloads on rotate so the old digit never ghosts onto the new anode
  always_comb begin
    bcnt_d = bcnt_q;
    if (rotate) begin
      bcnt_d = BCNT_LOAD;
    end else if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - BW'(1);
    end
    blank_win = (bcnt_q != '0);
  end

  // Flash timer: counts rotate pulses; held cleared while flash is low so
  // re-enabling always starts visible
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!flash) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (rotate) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    flash_off = flash & phase_q;
  end

  // Digit select from the one-cold anode vector and BCD decode
  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    case (anode)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_valid = 1'b0;
    endcase
    nibble = digits[{sel_idx, 2'b00} +: 4];
    case (nibble)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = SEG_DARK;
    endcase
    lz_kill = blank_lz && (sel_idx == 2'd3) && (nibble == 4'd0);
  end

  // Output pin values: dark whenever anything says so, else the selected digit
  always_comb begin
    seg_d = SEG_DARK;
    dp_d  = 1'b1;
    an_d  = 4'hF;
    if (!(rst || blank_win || flash_off || !sel_valid)) begin
      seg_d = lz_kill ? SEG_DARK : seg_dec;
      dp_d  = ~dp_mask[sel_idx];
      an_d  = anode;
    end
  end

  // State and pin registers; output pins already carry the reset-dark value in their _d
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
    seg_q <= seg_d;
    dp_q  <= dp_d;
    an_q  <= an_d;
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign an_out = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances with different timing parameters
// share one stimulus; a cycle-level reference model checks both every clock.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anode;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        flash;

  logic        rot_a, dp_a, rot_b, dp_b;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .FLASH_TICKS(2)) u_a (
    .clk(clk), .rst(rst), .anode(anode), .digits(digits), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .flash(flash),
    .rotate(rot_a), .seg(seg_a), .dp(dp_a), .an_out(an_a));

  seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(0), .FLASH_TICKS(2)) u_b (
    .clk(clk), .rst(rst), .anode(anode), .digits(digits), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .flash(flash),
    .rotate(rot_b), .seg(seg_b), .dp(dp_b), .an_out(an_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] segs_ref [16];
  int m_t  [2];   // cycles since reset release
  int m_sr [2];   // cycles since the last rotate edge (saturating)
  int m_fp [2];   // rotate pulses seen while flash stayed high
  bit model_ok = 1'b0;

  function automatic int p_div(input int k);   return (k == 0) ? 8 : 4; endfunction
  function automatic int p_blank(input int k); return (k == 0) ? 2 : 0; endfunction
  function automatic int p_ft(input int k);    return 2;                endfunction

  function automatic logic model_rot(input int k);
    return ((m_t[k] % p_div(k)) == p_div(k) - 1);
  endfunction

  task automatic model_out(input int k, output logic [6:0] s, output logic d, output logic [3:0] a);
    int         idx;
    bit         blank, foff;
    logic [3:0] oh, nib;
    idx   = -1;
    blank = (m_sr[k] >= 1) && (m_sr[k] <= p_blank(k));
    foff  = flash && (((m_fp[k] / p_ft(k)) % 2) == 1);
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      if (anode == ~oh) idx = i;
    end
    s = 7'h7F; d = 1'b1; a = 4'hF;
    if (!rst && !blank && !foff && idx >= 0) begin
      nib = digits[idx*4 +: 4];
      s   = (blank_lz && idx == 3 && nib == 4'd0) ? 7'h7F : segs_ref[nib];
      d   = ~dp_mask[idx];
      a   = anode;
    end
  endtask

  task automatic model_step(input int k);
    bit r;
    if (rst) begin
      m_t[k] = 0; m_sr[k] = 1000; m_fp[k] = 0;
    end else begin
      r = model_rot(k);
      m_t[k]++;
      m_sr[k] = r ? 1 : ((m_sr[k] < 1000) ? m_sr[k] + 1 : m_sr[k]);
      m_fp[k] = !flash ? 0 : (r ? m_fp[k] + 1 : m_fp[k]);
    end
  endtask

  // One clock: check rotate for the current cycle, predict the registered
  // pins from the current inputs, advance, then check pins after the edge.
  task automatic cyc();
    logic [6:0] es [2];
    logic       ed [2];
    logic [3:0] ea [2];
    if (model_ok) begin
      chk("m_rot_a", 32'(rot_a), 32'(model_rot(0)));
      chk("m_rot_b", 32'(rot_b), 32'(model_rot(1)));
    end
    for (int k = 0; k < 2; k++) model_out(k, es[k], ed[k], ea[k]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    model_ok = 1'b1;
    @(negedge clk);
    chk("m_seg_a", 32'(seg_a), 32'(es[0]));
    chk("m_dp_a",  32'(dp_a),  32'(ed[0]));
    chk("m_an_a",  32'(an_a),  32'(ea[0]));
    chk("m_seg_b", 32'(seg_b), 32'(es[1]));
    chk("m_dp_b",  32'(dp_b),  32'(ed[1]));
    chk("m_an_b",  32'(an_b),  32'(ea[1]));
  endtask

  // ---------------- direct vectors ----------------
  typedef struct {
    logic [3:0]  anode;
    logic [15:0] digits;
    logic [3:0]  dpm;
    logic        lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] a, input logic [15:0] dg, input logic [3:0] m,
                              input logic lz, input logic [6:0] s, input logic d, input logic [3:0] an);
    vec_t v;
    v.anode = a; v.digits = dg; v.dpm = m; v.lz = lz; v.seg = s; v.dp = d; v.an = an;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    logic [3:0] oh;

    segs_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < 2; k++) begin m_t[k] = 0; m_sr[k] = 1000; m_fp[k] = 0; end

    tbl[0]  = mk(4'b1101, 16'h4321, 4'b0010, 1'b0, 7'h24, 1'b0, 4'b1101);
    tbl[1]  = mk(4'b1101, 16'h43B1, 4'b0010, 1'b0, 7'h7F, 1'b0, 4'b1101);
    tbl[2]  = mk(4'b1110, 16'h4321, 4'b0000, 1'b0, 7'h79, 1'b1, 4'b1110);
    tbl[3]  = mk(4'b1011, 16'h4321, 4'b0100, 1'b0, 7'h30, 1'b0, 4'b1011);
    tbl[4]  = mk(4'b0111, 16'h4321, 4'b0000, 1'b1, 7'h19, 1'b1, 4'b0111);
    tbl[5]  = mk(4'b0111, 16'h0321, 4'b1000, 1'b1, 7'h7F, 1'b0, 4'b0111);
    tbl[6]  = mk(4'b0111, 16'h0321, 4'b0000, 1'b0, 7'h40, 1'b1, 4'b0111);
    tbl[7]  = mk(4'b1100, 16'h4321, 4'b1111, 1'b0, 7'h7F, 1'b1, 4'hF);
    tbl[8]  = mk(4'b1111, 16'h4321, 4'b1111, 1'b0, 7'h7F, 1'b1, 4'hF);
    tbl[9]  = mk(4'b1110, 16'h0005, 4'b0000, 1'b0, 7'h12, 1'b1, 4'b1110);
    tbl[10] = mk(4'b1110, 16'h0006, 4'b0001, 1'b0, 7'h02, 1'b0, 4'b1110);
    tbl[11] = mk(4'b1101, 16'h0070, 4'b0000, 1'b0, 7'h78, 1'b1, 4'b1101);
    tbl[12] = mk(4'b1110, 16'h0008, 4'b0000, 1'b0, 7'h00, 1'b1, 4'b1110);
    tbl[13] = mk(4'b1011, 16'h0900, 4'b0100, 1'b0, 7'h10, 1'b0, 4'b1011);
    tbl[14] = mk(4'b1110, 16'h000F, 4'b0000, 1'b0, 7'h7F, 1'b1, 4'b1110);

    rst = 1'b1; anode = 4'hF; digits = '0; dp_mask = '0; blank_lz = 1'b0; flash = 1'b0;

    // Reset: dark pins, no rotate
    anode = 4'b1110;
    cyc();
    chk("reset_an_b", 32'(an_b), 32'hF);
    chk("reset_seg_a", 32'(seg_a), 32'h7F);
    chk("reset_dp_a", 32'(dp_a), 32'h1);
    cyc();
    chk("reset_rot_a", 32'(rot_a), 32'h0);

    // Rotate cadence on the REFRESH_DIV=4 instance
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("cad_rot_b", 32'(rot_b), 32'((c == 3) || (c == 7) || (c == 11)));
      cyc();
    end

    // Anti-ghost blanking: instance A dark for two cycles after each rotate, B never
    rst = 1'b1; digits = 16'h0005; cyc(); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 7) chk("blank_rot_a", 32'(rot_a), 32'h1);
      cyc();
      chk("blank_an_a", 32'(an_a), ((c == 8) || (c == 9)) ? 32'hF : 32'hE);
      chk("blank_an_b", 32'(an_b), 32'hE);
    end

    // Decode / select / suppression vectors on instance B
    for (int i = 0; i < 15; i++) begin
      anode = tbl[i].anode; digits = tbl[i].digits; dp_mask = tbl[i].dpm; blank_lz = tbl[i].lz;
      cyc();
      chk($sformatf("vec%0d_seg", i), 32'(seg_b), 32'(tbl[i].seg));
      chk($sformatf("vec%0d_dp", i),  32'(dp_b),  32'(tbl[i].dp));
      chk($sformatf("vec%0d_an", i),  32'(an_b),  32'(tbl[i].an));
    end

    // Flash on B: 8 visible, 8 dark; dropping flash mid-dark shows next cycle
    anode = 4'b1110; digits = 16'h0001; blank_lz = 1'b0; dp_mask = '0;
    rst = 1'b1; flash = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 44; c++) begin
      if (c == 42) flash = 1'b0;
      cyc();
      chk("flash_an_b", 32'(an_b), ((c < 42) && (((c / 8) % 2) == 1)) ? 32'hF : 32'hE);
    end

    // Reset in the middle of a blank window while flash phase is dark
    anode = 4'b1101;
    rst = 1'b1; flash = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 25; c++) cyc();
    rst = 1'b1;
    cyc();
    chk("rstmid_an_a", 32'(an_a), 32'hF);
    chk("rstmid_seg_a", 32'(seg_a), 32'h7F);
    chk("rstmid_dp_a", 32'(dp_a), 32'h1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("rstmid_rot_a", 32'(rot_a), 32'(c == 7));
      cyc();
      chk("rstmid_an_vis_a", 32'(an_a), 32'hD);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) flash = ~flash;
      if ($urandom_range(0, 7) == 0) begin
        anode = 4'($urandom);
      end else begin
        oh = 4'b0001 << $urandom_range(0, 3);
        anode = ~oh;
      end
      digits   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) digits[15:12] = 4'd0;
      dp_mask  = 4'($urandom);
      blank_lz = 1'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
